// File: rtl/pcm_ram_writer.sv
// pcm_ram_writer: packs PCM frames into 32-bit words and fills a ping-pong RAM split.
// Optional per-half header word {16'hCAFE, seq}: define PCM_RAM_WRITER_HEADER_EN.
module pcm_ram_writer #(
    parameter int MIC_N    = 2,
    parameter int ADDR_W   = 10,
    parameter int SAMPLE_W = 16
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset_n,
    input  logic                      capture_en,
    input  logic                      sample_valid,
    input  logic [MIC_N*SAMPLE_W-1:0] sample_data,
    input  logic [1:0]                buf_ack,
    output logic [ADDR_W-1:0]         ram_address,
    output logic                      ram_chipselect,
    output logic                      ram_write,
    output logic [31:0]               ram_writedata,
    output logic [3:0]                ram_byteenable,
    output logic [1:0]                buf_ready,
    output logic                      active_half,
    output logic [15:0]               overrun_count
);
    localparam int WPF = MIC_N / 2;
    localparam int H   = 2 ** (ADDR_W - 1);
    localparam int KW  = (WPF > 1) ? $clog2(WPF) : 1;
    localparam int PW  = ADDR_W - 1;
`ifdef PCM_RAM_WRITER_HEADER_EN
    localparam int END_WP = 1 + WPF * ((H - 1) / WPF);
`else
    localparam int END_WP = H;
`endif

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_FULL} state_t;

    state_t                    r_state, w_next;
    logic [MIC_N*SAMPLE_W-1:0] r_hold;
    logic [PW-1:0]             r_wp;
    logic [KW-1:0]             r_k;
    logic                      r_half;
    logic [1:0]                r_ready;
    logic [15:0]               r_ovr;

    logic                      w_accept, w_hdr, w_last, w_full;
    logic [ADDR_W-1:0]         w_wp_inc;
    logic [1:0]                w_set;
    logic [31:0]               w_word;
    logic [31:0]               w_words [2**KW];

    for (genvar j = 0; j < 2**KW; j++) begin : g_w
        if (j < WPF) begin : g_v
            assign w_words[j] = r_hold[32*j +: 32];
        end else begin : g_z
            assign w_words[j] = '0;
        end
    end

    assign w_word   = w_words[r_k];
    assign w_accept = sample_valid & capture_en;

`ifdef PCM_RAM_WRITER_HEADER_EN
    logic [15:0] r_seq;
    // header slot is the first word of every half
    assign w_hdr = (r_state == S_WRITE) && (r_wp == '0);

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) r_seq <= '0;
        else if (w_full)    r_seq <= r_seq + 16'd1;
    end
`else
    assign w_hdr = 1'b0;
`endif

    assign w_last   = (r_state == S_WRITE) && !w_hdr && (r_k == KW'(WPF - 1));
    assign w_wp_inc = {1'b0, r_wp} + ADDR_W'(1);
    assign w_full   = w_last && (w_wp_inc == ADDR_W'(END_WP));
    assign w_set    = {w_full & r_half, w_full & ~r_half};

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            r_state <= S_IDLE;
            r_hold  <= '0;
            r_wp    <= '0;
            r_k     <= '0;
            r_half  <= 1'b0;
            r_ready <= '0;
            r_ovr   <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && w_accept)
                r_hold <= sample_data;
            if (r_state == S_WRITE) begin
                r_wp <= w_full ? '0 : r_wp + PW'(1);
                if (w_last)     r_k <= '0;
                else if (!w_hdr) r_k <= r_k + KW'(1);
            end
            if (w_full)
                r_half <= ~r_half;
            r_ready <= (r_ready & ~buf_ack) | w_set;
            if (r_state != S_IDLE && w_accept && r_ovr != 16'hFFFF)
                r_ovr <= r_ovr + 16'd1;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept) w_next = S_WRITE;
            S_WRITE: if (w_last) begin
                if (w_full && r_ready[~r_half]) w_next = S_FULL;
                else                            w_next = S_IDLE;
            end
            S_FULL:  if (buf_ack[r_half] || !r_ready[r_half]) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // write is gated by reset so it drops without waiting for the state register
    always_comb begin
        ram_write     = (r_state == S_WRITE) && reset_reset_n;
        ram_writedata = '0;
        if (ram_write) begin
            ram_writedata = w_word;
`ifdef PCM_RAM_WRITER_HEADER_EN
            if (w_hdr) ram_writedata = {16'hCAFE, r_seq};
`endif
        end
    end

    assign ram_chipselect = ram_write;
    assign ram_address    = {r_half, r_wp};
    assign ram_byteenable = 4'hF;
    assign buf_ready      = r_ready;
    assign active_half    = r_half;
    assign overrun_count  = r_ovr;
endmodule

// File: tb/tb_pcm_ram_writer.sv
// Scoreboard bench for pcm_ram_writer: MIC_N=2 and MIC_N=4 instances, ADDR_W=4 (H=8).
// Header expectations follow PCM_RAM_WRITER_HEADER_EN when it is defined.
module tb_pcm_ram_writer;
    localparam int AW = 4;
`ifdef PCM_RAM_WRITER_HEADER_EN
    localparam bit HDR = 1'b1;
`else
    localparam bit HDR = 1'b0;
`endif

    logic        clk, rst_n, cap_en;
    logic [1:0]  ack;
    logic        v2, v4;
    logic [31:0] sd2;
    logic [63:0] sd4;

    logic [AW-1:0] a2, a4;
    logic          cs2, cs4, w2, w4, ah2, ah4;
    logic [31:0]   wd2, wd4;
    logic [3:0]    be2, be4;
    logic [1:0]    br2, br4;
    logic [15:0]   ov2, ov4;

    int total = 0;
    int bad   = 0;

    logic [35:0] q2[$];
    logic [35:0] q4[$];

    int          m_half, m_wp, m_ovr, m4_wp;
    bit          m_full;
    logic [1:0]  m_ready;
    logic [15:0] m_seq;

    pcm_ram_writer #(.MIC_N(2), .ADDR_W(AW)) u_d2 (
        .clk_clk(clk), .reset_reset_n(rst_n), .capture_en(cap_en),
        .sample_valid(v2), .sample_data(sd2), .buf_ack(ack),
        .ram_address(a2), .ram_chipselect(cs2), .ram_write(w2),
        .ram_writedata(wd2), .ram_byteenable(be2), .buf_ready(br2),
        .active_half(ah2), .overrun_count(ov2)
    );

    pcm_ram_writer #(.MIC_N(4), .ADDR_W(AW)) u_d4 (
        .clk_clk(clk), .reset_reset_n(rst_n), .capture_en(cap_en),
        .sample_valid(v4), .sample_data(sd4), .buf_ack(2'b00),
        .ram_address(a4), .ram_chipselect(cs4), .ram_write(w4),
        .ram_writedata(wd4), .ram_byteenable(be4), .buf_ready(br4),
        .active_half(ah4), .overrun_count(ov4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [35:0] e;
        if (w2) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL d2_write got=%h_%h want=none", a2, wd2);
            end else begin
                e = q2.pop_front();
                if ({a2, wd2} !== e || cs2 !== 1'b1) begin
                    bad++;
                    $display("FAIL d2_write got=%h_%h cs=%b want=%h_%h",
                             a2, wd2, cs2, e[35:32], e[31:0]);
                end
            end
        end
        if (w4) begin
            total++;
            if (q4.size() == 0) begin
                bad++;
                $display("FAIL d4_write got=%h_%h want=none", a4, wd4);
            end else begin
                e = q4.pop_front();
                if ({a4, wd4} !== e || cs4 !== 1'b1) begin
                    bad++;
                    $display("FAIL d4_write got=%h_%h cs=%b want=%h_%h",
                             a4, wd4, cs4, e[35:32], e[31:0]);
                end
            end
        end
    end

    task automatic model_reset();
        m_half = 0; m_wp = 0; m_ovr = 0; m4_wp = 0;
        m_full = 1'b0; m_ready = 2'b00; m_seq = 16'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic model2(input logic [31:0] d);
        if (!cap_en) return;
        if (m_full) begin
            m_ovr++;
            return;
        end
        if (HDR && m_wp == 0) begin
            q2.push_back({4'(m_half*8), 16'hCAFE, m_seq});
            m_wp = 1;
        end
        q2.push_back({4'(m_half*8 + m_wp), d});
        m_wp++;
        if (m_wp == 8) begin
            m_wp = 0;
            m_ready[m_half] = 1'b1;
            m_half ^= 1;
            m_seq++;
            m_full = m_ready[m_half];
        end
    endtask

    task automatic send2(input logic [31:0] d);
        @(posedge clk); #1;
        v2 = 1'b1; sd2 = d;
        model2(d);
        @(posedge clk); #1;
        v2 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_q_empty(input string nm);
        total++;
        if (q2.size() != 0 || q4.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got=%0d/%0d want=0/0", nm, q2.size(), q4.size());
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        total++;
        if ({w2, cs2} !== 2'b00) begin
            bad++; $display("FAIL rst_write got=%b want=00", {w2, cs2});
        end
        total++;
        if (a2 !== 4'd0 || wd2 !== 32'd0) begin
            bad++; $display("FAIL rst_addr_data got=%h_%h want=0_0", a2, wd2);
        end
        total++;
        if (be2 !== 4'hF) begin
            bad++; $display("FAIL rst_be got=%h want=f", be2);
        end
        total++;
        if ({br2, ah2, ov2} !== 19'd0) begin
            bad++; $display("FAIL rst_status got=%b_%b_%h want=0", br2, ah2, ov2);
        end
    endtask

    task automatic test_first_word();
        logic [31:0] exp_d;
        exp_d = HDR ? 32'hCAFE0000 : 32'h1234ABCD;
        @(posedge clk); #1;
        v2 = 1'b1; sd2 = 32'h1234ABCD;
        model2(sd2);
        @(posedge clk); #1;
        v2 = 1'b0;
        @(negedge clk);
        total++;
        if ({w2, cs2, be2} !== 6'b11_1111) begin
            bad++; $display("FAIL first_ctrl got=%b%b_%h want=11_f", w2, cs2, be2);
        end
        total++;
        if (a2 !== 4'd0 || wd2 !== exp_d) begin
            bad++; $display("FAIL first_word got=%h_%h want=0_%h", a2, wd2, exp_d);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_q_empty("first");
    endtask

    task automatic test_fill();
        do_reset();
        for (int i = 0; i < 8; i++) send2(32'hA000_0000 + i);
        total++;
        if (br2 !== 2'b01 || ah2 !== 1'b1) begin
            bad++; $display("FAIL fill_ready got=%b_%b want=01_1", br2, ah2);
        end
        send2(32'hA000_0008);
        check_q_empty("fill");
    endtask

    task automatic test_overrun();
        do_reset();
        for (int i = 0; i < 32 && m_ready != 2'b11; i++) send2($urandom);
        total++;
        if (br2 !== 2'b11 || ov2 !== 16'd0) begin
            bad++; $display("FAIL ovr_full got=%b_%h want=11_0", br2, ov2);
        end
        for (int i = 0; i < 5; i++) send2($urandom);
        total++;
        if (ov2 !== 16'd5) begin
            bad++; $display("FAIL ovr_count got=%0d want=5", ov2);
        end
        check_q_empty("ovr_nowrite");
        @(posedge clk); #1 ack = 2'b01;
        @(posedge clk); #1 ack = 2'b00;
        m_ready[0] = 1'b0;
        m_full = 1'b0;
        send2(32'h5A5A_0001);
        check_q_empty("ovr_resume");
        total++;
        if (br2 !== 2'b10 || ov2 !== 16'd5) begin
            bad++; $display("FAIL ovr_after_ack got=%b_%0d want=10_5", br2, ov2);
        end
    endtask

    task automatic test_capture_ack();
        cap_en = 1'b0;
        send2(32'hDEAD_BEEF);
        cap_en = 1'b1;
        total++;
        if (ov2 !== 16'd5) begin
            bad++; $display("FAIL capen_ovr got=%0d want=5", ov2);
        end
        check_q_empty("capen");
        @(posedge clk); #1 ack = 2'b01;
        @(posedge clk); #1 ack = 2'b00;
        @(negedge clk);
        total++;
        if (br2 !== 2'b10) begin
            bad++; $display("FAIL stray_ack got=%b want=10", br2);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] fa;
        do_reset();
        fa = 64'h1111_2222_3333_4444;
        @(posedge clk); #1;
        v4 = 1'b1; sd4 = fa;
        if (HDR) begin
            q4.push_back({4'd0, 32'hCAFE0000});
            m4_wp = 1;
        end
        q4.push_back({4'(m4_wp), fa[31:0]});
        q4.push_back({4'(m4_wp + 1), fa[63:32]});
        m4_wp += 2;
        @(posedge clk); #1;
        sd4 = 64'h9999_8888_7777_6666;
        @(negedge clk);
        total++;
        if (w4 !== 1'b1) begin
            bad++; $display("FAIL b2b_first_write got=%b want=1", w4);
        end
        @(posedge clk); #1;
        v4 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (ov4 !== 16'd1) begin
            bad++; $display("FAIL b2b_ovr got=%0d want=1", ov4);
        end
        check_q_empty("b2b");
    endtask

    task automatic test_reset_mid();
        logic [63:0] fc;
        fc = 64'hAAAA_BBBB_CCCC_DDDD;
        @(posedge clk); #1;
        v4 = 1'b1; sd4 = fc;
        q4.push_back({4'(m4_wp), fc[31:0]});
        @(posedge clk); #1;
        v4 = 1'b0;
        @(negedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk); #1;
        total++;
        if (w4 !== 1'b0) begin
            bad++; $display("FAIL rstmid_write got=%b want=0", w4);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        total++;
        if (a4 !== 4'd0 || br4 !== 2'b00 || ov4 !== 16'd0) begin
            bad++; $display("FAIL rstmid_state got=%h_%b_%0d want=0_00_0", a4, br4, ov4);
        end
        check_q_empty("rstmid");
    endtask

    initial begin
        rst_n = 1'b0; cap_en = 1'b1; ack = 2'b00;
        v2 = 1'b0; v4 = 1'b0; sd2 = '0; sd4 = '0;
        model_reset();
        test_reset();
        test_first_word();
        test_fill();
        test_overrun();
        test_capture_ack();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
